// File: rtl/ones_pkg.sv
// Shared definitions for the ones-count controller: FSM state encodings and
// the constant log2 helper used to size the count.
package ones_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Ceiling log2. CW = clog2(N+1) holds any count from 0 to N.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ones_count_ctrl_if.sv
// Start/busy/done handshake between the OneCounter datapath and the
// ones-count controller.
interface ones_count_ctrl_if #(
  parameter int N = 8
) ();
  localparam int CW = ones_pkg::clog2(N + 1);

  logic          i_start;
  logic [N-1:0]  i_data;
  logic          o_busy;
  logic          o_done;
  logic [CW-1:0] o_count;

  modport master (
    output i_start,
    output i_data,
    input  o_busy,
    input  o_done,
    input  o_count
  );

  modport slave (
    input  i_start,
    input  i_data,
    output o_busy,
    output o_done,
    output o_count
  );
endinterface

// File: rtl/ones_count_ctrl_shifter_nb.sv
// n-bit loadable bidirectional shifter with active-low parallel load and
// asynchronous active-low clear.
module shifter_nb #(
  parameter int n = 8
) (
  input  logic         i_clk,
  input  logic         i_clr_,
  input  logic         i_load_,
  input  logic         i_leftRight,
  input  logic         i_shiftIn,
  input  logic [n-1:0] i_data,
  output logic [n-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_clr_) begin
    if (!i_clr_) begin
      o_q <= '0;
    end else if (!i_load_) begin
      o_q <= i_data;
    end else if (!i_leftRight) begin
      o_q <= {o_q[n-2:0], i_shiftIn};
    end else begin
      o_q <= {i_shiftIn, o_q[n-1:1]};
    end
  end

endmodule

// File: rtl/ones_count_ctrl.sv
// Ones-count sequencing controller: loads the operand into shifter_nb and
// accumulates the MSB once per clock. Optional build macro: ONES_EARLY_EXIT_EN.
//
// state   | meaning
// S_IDLE  | wait for a start
// S_SHIFT | shift and accumulate, one bit per clock
// S_DONE  | one cycle; o_count holds the new result, o_done high
module ones_count_ctrl
  import ones_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              i_clk,
  input  logic              i_clr_,
  ones_count_ctrl_if.slave  bus
);

  localparam int CW = clog2(N + 1);

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  shift_q;
  logic [CW-1:0] acc;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] count_r;
  logic [CW-1:0] acc_sum;
  logic          accept;
  logic          last_shift;

  assign accept  = bus.i_start & ((state == S_IDLE) | (state == S_DONE));
  assign acc_sum = acc + CW'(shift_q[N-1]);

`ifdef ONES_EARLY_EXIT_EN
  // Looking ahead at the bits below the MSB lets the final add and the exit
  // share one cycle, so a word whose lowest set bit is k from the MSB
  // finishes in k+2 cycles.
  assign last_shift = (bit_cnt == CW'(N - 1)) | (shift_q[N-2:0] == '0);
`else
  assign last_shift = (bit_cnt == CW'(N - 1));
`endif

  shifter_nb #(.n(N)) u_shifter (
    .i_clk       (i_clk),
    .i_clr_      (i_clr_),
    .i_load_     (~accept),
    .i_leftRight (1'b0),
    .i_shiftIn   (1'b0),
    .i_data      (bus.i_data),
    .o_q         (shift_q)
  );

  always_ff @(posedge i_clk or negedge i_clr_) begin
    if (!i_clr_) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (last_shift) state_nxt = S_DONE;
      S_DONE:  state_nxt = bus.i_start ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // o_count is written on the edge entering S_DONE so it is valid alongside o_done.
  always_ff @(posedge i_clk or negedge i_clr_) begin
    if (!i_clr_) begin
      acc     <= '0;
      bit_cnt <= '0;
      count_r <= '0;
    end else if (accept) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (state == S_SHIFT) begin
      acc     <= acc_sum;
      bit_cnt <= bit_cnt + CW'(1);
      if (last_shift) begin
        count_r <= acc_sum;
      end
    end
  end

  assign bus.o_busy  = (state == S_SHIFT);
  assign bus.o_done  = (state == S_DONE);
  assign bus.o_count = count_r;

endmodule

// File: tb/tb_ones_count_ctrl.sv
// Self-checking bench for ones_count_ctrl (N=8): directed cases plus random
// operands checked against a bit-counting reference model.
module tb_ones_count_ctrl;

  localparam int N = 8;

  logic clk  = 1'b0;
  logic clr_ = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   last_cnt = 0;

  always #5 clk = ~clk;

  ones_count_ctrl_if #(.N(N)) bus ();

  ones_count_ctrl #(.N(N)) dut (
    .i_clk  (clk),
    .i_clr_ (clr_),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_ones(input logic [N-1:0] d);
    int n = 0;
    for (int i = 0; i < N; i++) if (d[i]) n++;
    return n;
  endfunction

  function automatic int ref_lat(input logic [N-1:0] d);
`ifdef ONES_EARLY_EXIT_EN
    if (d == '0) return 2;
    for (int i = 0; i < N; i++) if (d[i]) return (N - 1 - i) + 2;
    return N + 1;
`else
    return N + 1;
`endif
  endfunction

  task automatic launch(input logic [N-1:0] d);
    bus.i_start = 1'b1;
    bus.i_data  = d;
    step();
    bus.i_start = 1'b0;
    bus.i_data  = N'($urandom);
  endtask

  // Called in cycle 1 of an operation; returns in its done cycle.
  task automatic watch(input logic [N-1:0] d, input int lo, input int hi);
    int lat = ref_lat(d);
    int exp = ref_ones(d);
    for (int c = 1; c <= lat; c++) begin
      if (c < lat) begin
        check("busy_in_shift", bus.o_busy, 1);
        check("no_done_in_shift", bus.o_done, 0);
        check("count_held", bus.o_count, last_cnt);
        bus.i_start = (c >= lo) && (c <= hi);
        if (bus.i_start) bus.i_data = 8'hFF;
        step();
      end else begin
        bus.i_start = 1'b0;
        check("busy_low_at_done", bus.o_busy, 0);
        check("done_pulse", bus.o_done, 1);
        check("count_result", bus.o_count, exp);
      end
    end
    last_cnt = exp;
  endtask

  task automatic idle(input int nc);
    repeat (nc) begin
      step();
      check("idle_busy", bus.o_busy, 0);
      check("idle_done", bus.o_done, 0);
      check("idle_count", bus.o_count, last_cnt);
    end
  endtask

  initial begin
    logic [N-1:0] d;
    int lo;
    bus.i_start = 1'b1;
    bus.i_data  = 8'hA5;

    // reset held with start asserted
    repeat (3) begin
      step();
      check("rst_busy", bus.o_busy, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_count", bus.o_count, 0);
    end
    bus.i_start = 1'b0;
    clr_ = 1'b1;
    idle(2);

    launch(8'hB5); watch(8'hB5, 0, 0); idle(2);
    launch(8'hFF); watch(8'hFF, 0, 0); idle(1);
    launch(8'h00); watch(8'h00, 0, 0); idle(1);

    // start while busy is ignored
    launch(8'h0F); watch(8'h0F, 2, 6); idle(3);

    // reset mid-shift
    launch(8'hFF);
    for (int c = 1; c <= 3; c++) begin
      check("pre_rst_busy", bus.o_busy, 1);
      step();
    end
    clr_ = 1'b0;
    #1;
    last_cnt = 0;
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_done", bus.o_done, 0);
    check("midrst_count", bus.o_count, 0);
    step();
    check("midrst_busy_held", bus.o_busy, 0);
    clr_ = 1'b1;
    idle(N + 2);
    launch(8'h0F); watch(8'h0F, 0, 0); idle(1);

    // back-to-back
    launch(8'h3C); watch(8'h3C, 0, 0);
    launch(8'h81); watch(8'h81, 0, 0); idle(1);

    // random operands, random chaining and ignored starts
    for (int k = 0; k < 24; k++) begin
      d  = N'($urandom);
      lo = $urandom_range(1, N);
      launch(d);
      watch(d, lo, lo + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
